speck32_round_engine: RTL and testbench



---
 rtl/speck32_round_engine.sv | 126 ++++++++++++
 tb/tb_speck32_round_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/speck32_round_engine.sv
// speck32_round_engine: iterative SPECK32/64 encryptor running one round per clock
module Adder_MIG (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s
);
    logic [16:0] c;

    function automatic logic maj(input logic p, input logic q, input logic r);
        return (p & q) | (p & r) | (q & r);
    endfunction

    assign c[0] = 1'b0;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign c[i+1] = maj(a[i], b[i], c[i]);
        // Majority-only full adder: s = M(~cout, cin, M(a, b, ~cin)).
        assign s[i]   = maj(~c[i+1], c[i], maj(a[i], b[i], ~c[i]));
    end
endmodule

module speck32_round_engine #(
    parameter int ROUNDS = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key,
    input  logic [31:0] pt,
    output logic        busy,
    output logic        done,
    output logic [31:0] ct
);
    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] round_q, round_d;
    logic [15:0]   x_q, x_d, y_q, y_d;
    logic [15:0]   k_q, k_d, l0_q, l0_d, l1_q, l1_d, l2_q, l2_d;
    logic [31:0]   ct_q, ct_d;
    logic [15:0]   sum_x, sum_k, x_new, y_new, l_new, k_new;

    Adder_MIG u_add_x (
        .a ({x_q[6:0], x_q[15:7]}),
        .b (y_q),
        .s (sum_x)
    );

    Adder_MIG u_add_k (
        .a (k_q),
        .b ({l0_q[6:0], l0_q[15:7]}),
        .s (sum_k)
    );

    assign x_new = sum_x ^ k_q;
    assign y_new = {y_q[13:0], y_q[15:14]} ^ x_new;
    assign l_new = sum_k ^ 16'(round_q);
    assign k_new = {k_q[13:0], k_q[15:14]} ^ l_new;

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign ct   = ct_q;

    // Next state: advance one round while running, otherwise accept a new block or fall back to idle.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        l0_d    = l0_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        ct_d    = ct_q;
        if (state_q == RUN) begin
            x_d     = x_new;
            y_d     = y_new;
            k_d     = k_new;
            l0_d    = l1_q;
            l1_d    = l2_q;
            l2_d    = l_new;
            round_d = round_q + CW'(1);
            if (round_q == LAST) begin
                ct_d    = {x_new, y_new};
                state_d = DONE;
            end
        end else if (start) begin
            {x_d, y_d}              = pt;
            {l2_d, l1_d, l0_d, k_d} = key;
            round_d                 = '0;
            state_d                 = RUN;
        end else begin
            state_d = IDLE;
        end
    end

    // State and datapath registers; reset clears everything including the held ciphertext.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            l0_q    <= '0;
            l1_q    <= '0;
            l2_q    <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            ct_q    <= ct_d;
        end
    end
endmodule

// File: tb/tb_speck32_round_engine.sv
// tb_speck32_round_engine: random and directed checks of the SPECK32/64 engine against a reference model
module tb_speck32_round_engine;
    localparam int R = 22;
    localparam logic [63:0] STD_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] STD_PT  = 32'h6574_694C;
    localparam logic [31:0] STD_CT  = 32'hA868_42F2;
    localparam logic [31:0] R1_CT   = 32'h5316_F627;

    logic        clk = 0, rst_n = 0, start = 0, start1 = 0;
    logic [63:0] key = '0;
    logic [31:0] pt = '0;
    logic        busy, done, busy1, done1;
    logic [31:0] ct, ct1;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    speck32_round_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .key   (key),
        .pt    (pt),
        .busy  (busy),
        .done  (done),
        .ct    (ct)
    );

    speck32_round_engine #(.ROUNDS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .key   (key),
        .pt    (pt),
        .busy  (busy1),
        .done  (done1),
        .ct    (ct1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ror16(input logic [15:0] v, input int n);
        return 16'((v >> n) | (v << (16 - n)));
    endfunction

    function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
        return 16'((v << n) | (v >> (16 - n)));
    endfunction

    function automatic logic [31:0] speck_ref(input logic [63:0] kk, input logic [31:0] pp, input int nr);
        logic [15:0] ks[$];
        logic [15:0] ls[$];
        logic [15:0] x, y;
        ks.push_back(kk[15:0]);
        ls.push_back(kk[31:16]);
        ls.push_back(kk[47:32]);
        ls.push_back(kk[63:48]);
        for (int i = 0; i < nr - 1; i++) begin
            ls.push_back((ks[i] + ror16(ls[i], 7)) ^ 16'(i));
            ks.push_back(rol16(ks[i], 2) ^ ls[i+3]);
        end
        x = pp[31:16];
        y = pp[15:0];
        for (int i = 0; i < nr; i++) begin
            x = (ror16(x, 7) + y) ^ ks[i];
            y = rol16(y, 2) ^ x;
        end
        return {x, y};
    endfunction

    task automatic run_one(input string tag, input logic [63:0] kk, input logic [31:0] pp,
                           input logic [31:0] exp, input int inj);
        int n, nb;
        @(negedge clk);
        key = kk;
        pt = pp;
        start = 1;
        @(negedge clk);
        start = 0;
        key = {$urandom, $urandom};
        pt = $urandom;
        n = 0;
        nb = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            if (n == inj) begin
                start = 1;
                key = '0;
                pt = '0;
            end else start = 0;
            @(negedge clk);
            n++;
        end
        start = 0;
        chk({tag, ".lat"}, 64'(n), 64'(R));
        chk({tag, ".busy_cycles"}, 64'(nb), 64'(R));
        chk({tag, ".ct"}, 64'(ct), 64'(exp));
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
        chk({tag, ".ct_hold"}, 64'(ct), 64'(exp));
    endtask

    initial begin
        logic [63:0] rk;
        logic [31:0] rp;
        int n, ndone, viol, last_t;
        repeat (2) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.ct", 64'(ct), 64'd0);
        chk("rst.ct1", 64'(ct1), 64'd0);
        rst_n = 1;

        run_one("std", STD_KEY, STD_PT, STD_CT, -1);

        @(negedge clk);
        key = STD_KEY;
        pt = STD_PT;
        start1 = 1;
        @(negedge clk);
        start1 = 0;
        chk("r1.busy", 64'(busy1), 64'd1);
        chk("r1.done_early", 64'(done1), 64'd0);
        @(negedge clk);
        chk("r1.done", 64'(done1), 64'd1);
        chk("r1.ct", 64'(ct1), 64'(R1_CT));
        chk("r1.busy_done", 64'(busy1), 64'd0);
        @(negedge clk);
        chk("r1.done_pulse", 64'(done1), 64'd0);

        for (int i = 0; i < 8; i++) begin
            rk = {$urandom, $urandom};
            rp = $urandom;
            run_one($sformatf("rand%0d", i), rk, rp, speck_ref(rk, rp, R), -1);
        end

        run_one("ignore_start", STD_KEY, STD_PT, STD_CT, 5);

        @(negedge clk);
        key = STD_KEY;
        pt = STD_PT;
        start = 1;
        n = 0;
        ndone = 0;
        viol = 0;
        last_t = -1;
        while (ndone < 3 && n < 200) begin
            @(negedge clk);
            if (busy === done) viol++;
            if (done) begin
                ndone++;
                chk($sformatf("b2b.ct%0d", ndone), 64'(ct), 64'(STD_CT));
                chk($sformatf("b2b.gap%0d", ndone), 64'(n - last_t), 64'(ndone == 1 ? R + 1 : R + 1));
                last_t = n;
                if (ndone == 3) start = 0;
            end
            n++;
        end
        start = 0;
        chk("b2b.count", 64'(ndone), 64'd3);
        chk("b2b.busy_vs_done", 64'(viol), 64'd0);
        @(negedge clk);

        rk = {$urandom, $urandom};
        rp = $urandom;
        run_one("pre_rst", rk, rp, speck_ref(rk, rp, R), -1);

        @(negedge clk);
        key = STD_KEY;
        pt = STD_PT;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (10) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst.busy", 64'(busy), 64'd0);
        chk("mid_rst.done", 64'(done), 64'd0);
        chk("mid_rst.ct", 64'(ct), 64'd0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mid_rst.no_done", 64'(ndone), 64'd0);
        rst_n = 1;
        run_one("post_rst", STD_KEY, STD_PT, STD_CT, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
